// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M/RV64M multiply/divide unit beside the EX-stage ALU
// Optional feature: define MULDIV_EARLY_OUT_EN to skip iteration on a zero divisor or zero multiply operand.
module ex_muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [XLEN-1:0]       op1_i,
  input  logic [XLEN-1:0]       op2_i,
  input  logic [REG_ADDR_W-1:0] wr_reg_addr_i,
  input  logic                  flush_i,
  output logic                  stall_req_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [XLEN-1:0]       result_o,
  output logic                  wr_bck_en_o,
  output logic [REG_ADDR_W-1:0] wr_reg_addr_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              op_q, op_d;
  logic [XLEN-1:0]         b_q, b_d;
  logic [2*XLEN-1:0]       acc_q, acc_d;
  logic                    neg_quo_q, neg_quo_d;
  logic                    neg_rem_q, neg_rem_d;
  logic                    div_zero_q, div_zero_d;
  logic                    ovf_q, ovf_d;
  logic                    done_q, done_d;
  logic [XLEN-1:0]         result_q, result_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;

  logic                    launch;
  logic                    in_is_div;
  logic                    a_signed, b_signed;
  logic                    a_neg, b_neg;
  logic [XLEN-1:0]         a_mag, b_mag;

  always_comb begin
    launch    = (state_q == S_IDLE) && start_i && !flush_i;
    in_is_div = op_i[2];
    a_signed  = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    b_signed  = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    a_neg     = a_signed && op1_i[XLEN-1];
    b_neg     = b_signed && op2_i[XLEN-1];
    a_mag     = a_neg ? -op1_i : op1_i;
    b_mag     = b_neg ? -op2_i : op2_i;
  end

  // acc holds {partial product, multiplier} for MUL* and {remainder, dividend/quotient} for DIV*
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_tmp;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   quo_raw, rem_raw;
  logic [XLEN-1:0]   quo_fin, rem_fin;
  logic [XLEN-1:0]   calc_result;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    div_tmp  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge   = div_tmp >= {1'b0, b_q};
    div_diff = div_tmp[XLEN-1:0] - b_q;
    if (op_q[2]) begin
      acc_step = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                        : {div_tmp[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end

    prod_signed = neg_quo_q ? -acc_step : acc_step;
    quo_raw     = acc_step[XLEN-1:0];
    rem_raw     = acc_step[2*XLEN-1:XLEN];

    if (div_zero_q)  quo_fin = {XLEN{1'b1}};
    else if (ovf_q)  quo_fin = MIN_NEG;
    else             quo_fin = neg_quo_q ? -quo_raw : quo_raw;

    // a zero divisor leaves the dividend magnitude in the remainder, so the sign fix restores it
    if (ovf_q)       rem_fin = '0;
    else             rem_fin = neg_rem_q ? -rem_raw : rem_raw;

    case (op_q)
      OP_MUL:                       calc_result = prod_signed[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_result = prod_signed[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              calc_result = quo_fin;
      default:                      calc_result = rem_fin;
    endcase
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic            early_out;
  logic [XLEN-1:0] early_result;

  always_comb begin
    early_out = in_is_div ? (op2_i == '0) : ((op1_i == '0) || (op2_i == '0));
    case (op_i)
      OP_DIV, OP_DIVU: early_result = {XLEN{1'b1}};
      OP_REM, OP_REMU: early_result = op1_i;
      default:         early_result = '0;
    endcase
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    b_d        = b_q;
    acc_d      = acc_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    result_d   = result_q;
    rd_d       = rd_q;

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          op_d       = op_i;
          rd_d       = wr_reg_addr_i;
          cnt_d      = '0;
          b_d        = in_is_div ? b_mag : a_mag;
          acc_d      = {{XLEN{1'b0}}, (in_is_div ? a_mag : b_mag)};
          neg_quo_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          div_zero_d = (op2_i == '0);
          ovf_d      = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                       (op1_i == MIN_NEG) && (op2_i == {XLEN{1'b1}});
`ifdef MULDIV_EARLY_OUT_EN
          if (early_out) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = early_result;
          end else begin
            state_d  = S_CALC;
          end
`else
          state_d    = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = calc_result;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      result_q   <= result_d;
      rd_q       <= rd_d;
    end
  end

  // stall is low in DONE so the pipeline captures the result that cycle
  assign stall_req_o   = launch || (state_q == S_CALC);
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign wr_bck_en_o   = done_q;
  assign result_o      = result_q;
  assign wr_reg_addr_o = rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit (XLEN=32)
// Define MULDIV_EARLY_OUT_EN for both bench and RTL to exercise the early-out build.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] op1_i = '0;
  logic [31:0] op2_i = '0;
  logic [4:0]  rd_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_req_o, busy_o, done_o, wr_bck_en_o;
  logic [31:0] result_o;
  logic [4:0]  wr_reg_addr_o;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .op_i          (op_i),
    .op1_i         (op1_i),
    .op2_i         (op2_i),
    .wr_reg_addr_i (rd_i),
    .flush_i       (flush_i),
    .stall_req_o   (stall_req_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .result_o      (result_o),
    .wr_bck_en_o   (wr_bck_en_o),
    .wr_reg_addr_o (wr_reg_addr_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (op[2] ? (b == 0) : (a == 0 || b == 0)) return 1;
`endif
    return 33 + 0 * int'(op) + 0 * int'(a[0]) + 0 * int'(b[0]);
  endfunction

  // Cycle model: m_left counts cycles until the unit is idle again; 1 means this is the done cycle.
  int          m_left = 0;
  int          m_nl;
  logic [31:0] m_result = '0;
  logic [31:0] m_pend = '0;
  logic [4:0]  m_rd = '0;

  always_comb begin
    m_nl = m_left;
    if (m_left == 0) begin
      if (start_i && !flush_i) m_nl = lat_of(op_i, op1_i, op2_i);
    end else if (flush_i || m_left == 1) begin
      m_nl = 0;
    end else begin
      m_nl = m_left - 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left   <= 0;
      m_result <= '0;
      m_pend   <= '0;
      m_rd     <= '0;
    end else begin
      m_left <= m_nl;
      if (m_left == 0 && start_i && !flush_i) begin
        m_pend <= model_res(op_i, op1_i, op2_i);
        m_rd   <= rd_i;
      end
      if (m_nl == 1) m_result <= (m_left == 0) ? model_res(op_i, op1_i, op2_i) : m_pend;
    end
  end

  always @(negedge clk) begin
    chk("busy",   64'(busy_o),        64'(m_left != 0));
    chk("done",   64'(done_o),        64'(m_left == 1));
    chk("wbe",    64'(wr_bck_en_o),   64'(m_left == 1));
    chk("stall",  64'(stall_req_o),   64'(((m_left == 0) && start_i && !flush_i) || (m_left > 1)));
    chk("result", 64'(result_o),      64'(m_result));
    chk("rd",     64'(wr_reg_addr_o), 64'(m_rd));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int t0, output int s0);
    start_i = 1'b1;
    op_i    = op;
    op1_i   = a;
    op2_i   = b;
    rd_i    = rd;
    t0      = cyc;
    @(negedge clk);
    s0 = int'(stall_req_o);
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int t0, output int lat, output int sc);
    lat = -1;
    sc  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_o) begin
        lat = cyc - t0;
        return;
      end
      sc += int'(stall_req_o);
    end
    checks++;
    errors++;
    $display("FAIL done_timeout cyc %0d: got no done_o expected done_o within 100 cycles", cyc);
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] e);
    int t0, s0, lat, sc;
    chk("model_pin", 64'(model_res(op, a, b)), 64'(e));
    launch(op, a, b, rd, t0, s0);
    wait_done(t0, lat, sc);
    chk("latency",      64'(lat),           64'(lat_of(op, a, b)));
    chk("result_lit",   64'(result_o),      64'(e));
    chk("rd_lit",       64'(wr_reg_addr_o), 64'(rd));
    chk("stall_cycles", 64'(s0 + sc),       64'(lat_of(op, a, b)));
    tick();
  endtask

  logic [2:0]  v_op [19] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd1, 3'd0, 3'd4, 3'd6, 3'd5, 3'd7,
                             3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd4, 3'd7, 3'd5};
  logic [31:0] v_a  [19] = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'd0, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                             32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd9,
                             32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] v_b  [19] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd2, 32'd3,
                             32'd5, 32'd2, 32'd2, 32'd7, 32'd7,
                             32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,
                             32'd0, 32'd0, 32'd10, 32'd10};
  logic [31:0] v_e  [19] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'd0, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                             32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF,
                             32'hFFFFFFF9, 32'hFFFFFFFF, 32'd5, 32'h19999999};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, t1, s0, lat, sc, dseen;
    logic [31:0] prev;

    tick();
    tick();
    @(negedge clk);
    chk("rst_busy",   64'(busy_o),        64'(0));
    chk("rst_done",   64'(done_o),        64'(0));
    chk("rst_result", 64'(result_o),      64'(0));
    chk("rst_rd",     64'(wr_reg_addr_o), 64'(0));
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 19; i++) run(v_op[i], v_a[i], v_b[i], 5'(i + 1), v_e[i]);

    // start ignored while busy
    launch(3'd0, 32'd6, 32'd7, 5'd3, t0, s0);
    while (cyc < t0 + 5) tick();
    start_i = 1'b1; op_i = 3'd4; op1_i = 32'd100; op2_i = 32'd7; rd_i = 5'd20;
    tick();
    start_i = 1'b0;
    wait_done(t0, lat, sc);
    chk("busy_start_lat", 64'(lat),           64'(33));
    chk("busy_start_res", 64'(result_o),      64'(42));
    chk("busy_start_rd",  64'(wr_reg_addr_o), 64'(3));
    prev = 32'd42;
    tick();

    // flush with start in IDLE launches nothing
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; op1_i = 32'd2; op2_i = 32'd3; rd_i = 5'd7;
    @(negedge clk);
    chk("flush_idle_stall", 64'(stall_req_o), 64'(0));
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk("flush_idle_busy", 64'(busy_o), 64'(0));
    tick();

    // flush in cycle 10 of a DIV, new MUL in cycle 11 completes in cycle 44
    launch(3'd4, 32'd1000, 32'd3, 5'd4, t0, s0);
    while (cyc < t0 + 10) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    start_i = 1'b1; op_i = 3'd0; op1_i = 32'd7; op2_i = 32'hFFFFFFFD; rd_i = 5'd5;
    t1 = cyc;
    @(negedge clk);
    chk("flush_busy_c11", 64'(busy_o),   64'(0));
    chk("flush_hold_res", 64'(result_o), 64'(prev));
    tick();
    start_i = 1'b0;
    wait_done(t1, lat, sc);
    chk("flush_new_done_cyc", 64'(t1 + lat - t0), 64'(44));
    chk("flush_new_res",      64'(result_o),      64'(32'hFFFFFFEB));
    tick();

    // asynchronous reset in cycle 5 of an op
    launch(3'd5, 32'd77, 32'd5, 5'd9, t0, s0);
    while (cyc < t0 + 5) tick();
    rst = 1'b1;
    #1;
    chk("arst_busy",   64'(busy_o),        64'(0));
    chk("arst_done",   64'(done_o),        64'(0));
    chk("arst_wbe",    64'(wr_bck_en_o),   64'(0));
    chk("arst_stall",  64'(stall_req_o),   64'(0));
    chk("arst_result", 64'(result_o),      64'(0));
    chk("arst_rd",     64'(wr_reg_addr_o), 64'(0));
    tick();
    rst = 1'b0;
    dseen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      dseen += int'(done_o);
    end
    chk("arst_no_done", 64'(dseen), 64'(0));
    tick();

    run(3'd4, 32'd9, 32'd0, 5'd11, 32'hFFFFFFFF);
    run(3'd5, 32'd100, 32'd7, 5'd12, 32'd14);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
